// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets in a FAULT state.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, FAULT} state_t;
`else
    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
`endif
    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] target;
    logic        discard;
    logic        grant;
    logic        busy;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    // A response is still owed unless it arrives in this very cycle.
    assign busy      = grant || (state == WAIT && !imem_rvalid);
`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign target      = redirect_pc;
    assign fetch_fault = fault_q;
`else
    assign target      = {redirect_pc[31:2], 2'b00};
    assign fetch_fault = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0013;
            pc          <= RESET_VECTOR;
            fetch_pc    <= RESET_VECTOR;
            discard     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else if (redirect) begin
            instr_valid <= 1'b0;
            fetch_pc    <= target;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
            if (target[1:0] != 2'b00) begin
                state    <= FAULT;
                imem_req <= 1'b0;
                discard  <= 1'b0;
                fault_q  <= 1'b1;
                pc       <= target;
            end else
`endif
            begin
                state    <= busy ? WAIT : FETCH;
                imem_req <= !busy;
                discard  <= busy;
            end
        end else begin
            case (state)
                FETCH: begin
                    state    <= grant ? WAIT : FETCH;
                    imem_req <= !grant;
                end
                WAIT: if (imem_rvalid) begin
                    state       <= discard ? FETCH : HOLD;
                    imem_req    <= discard;
                    instr_valid <= !discard;
                    discard     <= 1'b0;
                    if (!discard) begin
                        instr <= imem_rdata;
                        pc    <= fetch_pc;
                    end
                end
                HOLD: if (instr_ready) begin
                    state       <= FETCH;
                    imem_req    <= 1'b1;
                    instr_valid <= 1'b0;
                    fetch_pc    <= fetch_pc + 32'd4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; memory returns 0x0050_0093 + address.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, instr, pc, redirect_pc;
    logic [31:0] qa[$];
    logic [63:0] qi[$];
    int n_cmp = 0, n_bad = 0, n_gnt = 0, n_inj = 0, lat = 1;
    int cyc = 0, last_cons = 0, gap = 0;
    int mem_cnt = 0, mem_seen = 0;
    logic [31:0] mem_a = '0;
    logic [31:0] nxt;
    bit prev_cons = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int g0;
        g0 = n_gnt;
        imem_gnt = 1'b1;
        for (int i = 0; i < 20 && n_gnt == g0; i++) tick();
        imem_gnt = 1'b0;
        chk("gnt_timeout", 64'(n_gnt != g0), 64'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        chk("valid_timeout", 64'(instr_valid), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (qa.size() != 0 || qi.size() != 0); i++) tick();
        chk("drain_addr", 64'(qa.size()), 64'd0);
        chk("drain_instr", 64'(qi.size()), 64'd0);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect = 1'b1;
        redirect_pc = t;
        tick();
        redirect = 1'b0;
    endtask

    // Memory: responds lat cycles after a grant; n_inj bumps force a stray response.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (mem_seen != n_inj) begin
                mem_seen = n_inj;
                imem_rvalid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = 32'h0050_0093 + mem_a;
                end
            end
            @(negedge clk);
            if (!reset && imem_req && imem_gnt) begin
                mem_a = imem_addr;
                mem_cnt = lat;
                n_gnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (prev_cons) chk("valid_after_consume", 64'(instr_valid), 64'd0);
            prev_cons = instr_valid && instr_ready;
            if (imem_req && imem_gnt) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
                end else chk("req_addr", 64'(imem_addr), 64'(qa.pop_front()));
            end
            if (instr_valid && instr_ready) begin
                if (qi.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_consume: got pc %h instr %h expected none", pc, instr);
                end else chk("consume", {pc, instr}, qi.pop_front());
                gap = cyc - last_cons;
                last_cons = cyc;
            end
        end else prev_cons = 0;
    end

    initial begin
        reset = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'h13);
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        // Back-to-back fetch at best-case throughput
        qa.push_back(32'h0); qa.push_back(32'h4);
        qi.push_back({32'h0, 32'h0050_0093}); qi.push_back({32'h4, 32'h0050_0097});
        reset = 1'b0;
        tick();
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'h0);
        wait_gnt(); wait_gnt(); drain();
        chk("throughput", 64'(gap), 64'd3);
        // Decode stall in HOLD
        instr_ready = 1'b0;
        qa.push_back(32'h8); qi.push_back({32'h8, 32'h0050_009B});
        wait_gnt(); wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_instr", 64'(instr), 64'h0050_009B);
            chk("stall_pc", 64'(pc), 64'h8);
            chk("stall_req", 64'(imem_req), 64'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        chk("after_stall_addr", 64'(imem_addr), 64'hC);
        chk("after_stall_valid", 64'(instr_valid), 64'd0);
        // Redirect while waiting; stale response two cycles later must vanish
        lat = 3;
        qa.push_back(32'hC);
        wait_gnt();
        do_redirect(32'h100);
        lat = 1;
        tick(); tick(); tick();
        chk("discard_instr", 64'(instr), 64'h0050_009B);
        chk("discard_pc", 64'(pc), 64'h8);
        chk("discard_valid", 64'(instr_valid), 64'd0);
        chk("discard_req", 64'(imem_req), 64'd1);
        chk("discard_addr", 64'(imem_addr), 64'h100);
        qa.push_back(32'h100); qi.push_back({32'h100, 32'h0050_0193});
        wait_gnt(); drain();
        // PC wrap
        do_redirect(32'hFFFF_FFFC);
        qa.push_back(32'hFFFF_FFFC); qa.push_back(32'h0);
        qi.push_back({32'hFFFF_FFFC, 32'h0050_008F}); qi.push_back({32'h0, 32'h0050_0093});
        wait_gnt(); wait_gnt(); drain();
        chk("wrap_next_addr", 64'(imem_addr), 64'h4);
        // Redirect coinciding with consume: no +4, target fetched next
        instr_ready = 1'b0;
        qa.push_back(32'h4);
        wait_gnt(); wait_valid();
        qi.push_back({32'h4, 32'h0050_0097});
        instr_ready = 1'b1;
        do_redirect(32'h40);
        chk("redir_consume_addr", 64'(imem_addr), 64'h40);
        chk("redir_consume_valid", 64'(instr_valid), 64'd0);
        qa.push_back(32'h40); qi.push_back({32'h40, 32'h0050_00D3});
        wait_gnt(); drain();
        // Misaligned redirect target
        do_redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fault_set", 64'(fetch_fault), 64'd1);
        chk("fault_req", 64'(imem_req), 64'd0);
        chk("fault_pc", 64'(pc), 64'h102);
        tick(); tick();
        chk("fault_hold_req", 64'(imem_req), 64'd0);
        do_redirect(32'h200);
        chk("fault_clear", 64'(fetch_fault), 64'd0);
        chk("fault_exit_addr", 64'(imem_addr), 64'h200);
        qa.push_back(32'h200); qi.push_back({32'h200, 32'h0050_0293});
        nxt = 32'h204;
`else
        chk("misalign_addr", 64'(imem_addr), 64'h100);
        chk("misalign_fault", 64'(fetch_fault), 64'd0);
        chk("misalign_req", 64'(imem_req), 64'd1);
        qa.push_back(32'h100); qi.push_back({32'h100, 32'h0050_0193});
        nxt = 32'h104;
`endif
        wait_gnt(); drain();
        // Reset while holding an instruction, then a stray response
        instr_ready = 1'b0;
        qa.push_back(nxt);
        wait_gnt(); wait_valid();
        reset = 1'b1;
        tick();
        chk("midrst_valid", 64'(instr_valid), 64'd0);
        chk("midrst_instr", 64'(instr), 64'h13);
        chk("midrst_pc", 64'(pc), 64'h0);
        chk("midrst_req", 64'(imem_req), 64'd0);
        reset = 1'b0;
        n_inj++;
        tick(); tick(); tick();
        chk("stray_instr", 64'(instr), 64'h13);
        chk("stray_valid", 64'(instr_valid), 64'd0);
        chk("stray_addr", 64'(imem_addr), 64'h0);
        instr_ready = 1'b1;
        qa.push_back(32'h0); qi.push_back({32'h0, 32'h0050_0093});
        wait_gnt(); drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  word address of the request.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle (imem_req && imem_gnt).
REQ-007 imem_rvalid  input  1  read data valid; at least 1 cycle after the grant.
REQ-008 imem_rdata  input  32  instruction word returned.
REQ-009 instr  output  32  fetched instruction, feeds the decode stage instr input.
REQ-010 pc  output  32  address of the word on instr.
REQ-011 instr_valid  output  1  instr/pc valid to decode.
REQ-012 instr_ready  input  1  decode consumes instr this cycle (instr_valid && instr_ready).
REQ-013 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-014 redirect_pc  input  32  redirect target.
REQ-015 fetch_fault  output  1  misaligned redirect target (see Configuration).

Function
REQ-016 The FSM shall have states FETCH, WAIT and HOLD (plus FAULT when configured); at most one request is outstanding.
REQ-017 FETCH: imem_req=1, imem_addr=fetch_pc; on grant go to WAIT; imem_addr shall stay stable while imem_req=1 and imem_gnt=0, except in the cycle after a redirect.
REQ-018 WAIT: imem_req=0; on imem_rvalid, capture imem_rdata into instr and fetch_pc into pc, set instr_valid the next cycle, and go to HOLD.
REQ-019 HOLD: instr_valid=1 with instr/pc stable until consumed; on consume, fetch_pc+=4 and go to FETCH, with instr_valid=0 the next cycle.
REQ-020 Best-case throughput shall be one instruction per 3 cycles (grant in FETCH, rvalid 1 cycle later, consume on first HOLD cycle).
REQ-021 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 shall give 32'h0000_0000.
REQ-022 Redirect has highest priority in every state: fetch_pc<=redirect_pc, and instr_valid=0 the next cycle.
REQ-023 If a request is outstanding at redirect (WAIT, or a grant in the same cycle), a discard flag shall be set and the FSM shall stay in or enter WAIT; otherwise it shall go to FETCH.
REQ-024 With discard set, the next imem_rvalid is dropped (instr/pc unchanged), the flag clears, and the FSM goes to FETCH.
REQ-025 Redirect together with a consume in HOLD: the instruction counts as consumed, no +4 is applied, and the redirect target is fetched next.
REQ-026 imem_rvalid outside WAIT shall be ignored.

Reset
REQ-027 During reset: imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), pc=RESET_VECTOR, fetch_pc=RESET_VECTOR, discard=0, fetch_fault=0, state=FETCH.
REQ-028 imem_req shall assert on the first cycle after reset deasserts, with imem_addr=RESET_VECTOR.
REQ-029 Reset mid-operation aborts any outstanding request; a late imem_rvalid shall be ignored per REQ-026.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 shall enter FAULT, with no request issued, fetch_fault=1, and pc=redirect_pc; FAULT exits only on an aligned redirect (fetch_fault=0 the next cycle) or on reset.
REQ-031 Macro undefined: redirect_pc[1:0] is forced to 2'b00, FAULT does not exist, and fetch_fault is tied to 0 (the port is always present).

Verification
REQ-032 Reset release, memory grants immediately and returns rdata=32'h0050_0093 one cycle later, instr_ready=1 -> imem_addr 0x0, then 0x4; instr=0x0050_0093, pc=0x0 valid for exactly one cycle.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instr/pc/instr_valid stable, imem_req=0 throughout, no PC advance.
REQ-034 Redirect to 0x100 while in WAIT, stale rvalid 2 cycles later -> stale word never appears on instr; next imem_addr=0x100.
REQ-035 Start at 0xFFFF_FFFC via redirect, consume -> next imem_addr=0x0000_0000.
REQ-036 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_fault=1, imem_req=0; then redirect to 0x200 -> fetch_fault=0, imem_addr=0x200. Without the macro -> imem_addr=0x100, fetch_fault=0.
REQ-037 Assert reset while in HOLD -> next cycle instr_valid=0, instr=0x13, pc=RESET_VECTOR; a subsequent rvalid is ignored.
